// File: rtl/gtfmac_hwchk_bitslip_responder_if.sv
// Bitslip handshake bundle between the MAC-side bitslip corrector (master)
// and the emulated GT receiver responder (slave).
interface gtfmac_hwchk_bitslip_responder_if;
    logic [6:0] ctl_target_offset;
    logic       bs_gb_seq_sync;
    logic       bs_disable_bitslip;
    logic       bs_slip_pma;
    logic       bs_slip_one_ui;
    logic       rx_block_lock;
    logic       rx_bitslip;
    logic       rx_slip_pma_rdy;
    logic [6:0] stat_hunt_cnt;
    logic [6:0] stat_correct_cnt;
    logic [6:0] stat_residual;
    logic       stat_aligned;
    logic       stat_over_correct;

    modport master (
        output ctl_target_offset, bs_gb_seq_sync, bs_disable_bitslip,
               bs_slip_pma, bs_slip_one_ui,
        input  rx_block_lock, rx_bitslip, rx_slip_pma_rdy,
               stat_hunt_cnt, stat_correct_cnt, stat_residual,
               stat_aligned, stat_over_correct
    );

    modport slave (
        input  ctl_target_offset, bs_gb_seq_sync, bs_disable_bitslip,
               bs_slip_pma, bs_slip_one_ui,
        output rx_block_lock, rx_bitslip, rx_slip_pma_rdy,
               stat_hunt_cnt, stat_correct_cnt, stat_residual,
               stat_aligned, stat_over_correct
    );
endinterface

// File: rtl/gtfmac_hwchk_bitslip_responder.sv
// Far end of the GTFMAC RX bitslip handshake: emulates hunt slips, block lock
// and the slip-PMA ready handshake, and tracks how well the corrector undid the hunt.
module gtfmac_hwchk_bitslip_responder #(
    parameter int unsigned SLIP_INTERVAL = 16,
    parameter int unsigned RDY_LATENCY   = 8,
    parameter int unsigned LOCK_DELAY    = 4
) (
    input logic                             rx_clk,
    input logic                             rx_rst_n,
    gtfmac_hwchk_bitslip_responder_if.slave bus
);
    typedef enum logic [2:0] {
        ST_INIT,
        ST_HUNT,
        ST_LOCK_WAIT,
        ST_LOCKED,
        ST_RESYNC
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] target_q, target_d;
    logic [7:0] slip_tmr_q, slip_tmr_d;
    logic [7:0] lock_tmr_q, lock_tmr_d;
    logic [7:0] rdy_tmr_q, rdy_tmr_d;
    logic [6:0] hunt_cnt_q, hunt_cnt_d;
    logic [6:0] correct_cnt_q, correct_cnt_d;
    logic       rx_block_lock_q, rx_block_lock_d;
    logic       rx_bitslip_q, rx_bitslip_d;
    logic       rdy_q, rdy_d;
    logic       aligned_q, aligned_d;
    logic       over_q, over_d;
    logic       corr_seen_q, corr_seen_d;
    logic       pma_hist_q, pma_hist_d;
    logic       one_hist_q, one_hist_d;

    logic       pma_accept;
    logic       one_accept;
    logic       slip_due;
    logic       lock_due;
    logic [1:0] corr_inc;
    logic [7:0] corr_sum;

    // Requests only count on a rising edge, and only while the link is locked.
    assign pma_accept = (state_q == ST_LOCKED) && bus.bs_slip_pma && !pma_hist_q && rdy_q;
    assign one_accept = (state_q == ST_LOCKED) && bus.bs_slip_one_ui && !one_hist_q;
    assign slip_due   = (state_q == ST_HUNT) && !bus.bs_disable_bitslip &&
                        (hunt_cnt_q != target_q) && (slip_tmr_q == 8'(SLIP_INTERVAL - 1));
    assign lock_due   = (state_q == ST_LOCK_WAIT) && (lock_tmr_q == 8'(LOCK_DELAY - 1));
    assign corr_inc   = {pma_accept, one_accept};
    assign corr_sum   = {1'b0, correct_cnt_q} + {6'd0, corr_inc};

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q         <= ST_INIT;
            target_q        <= 7'd0;
            slip_tmr_q      <= 8'd0;
            lock_tmr_q      <= 8'd0;
            rdy_tmr_q       <= 8'd0;
            hunt_cnt_q      <= 7'd0;
            correct_cnt_q   <= 7'd0;
            rx_block_lock_q <= 1'b0;
            rx_bitslip_q    <= 1'b0;
            rdy_q           <= 1'b1;
            aligned_q       <= 1'b0;
            over_q          <= 1'b0;
            corr_seen_q     <= 1'b0;
            pma_hist_q      <= 1'b0;
            one_hist_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            slip_tmr_q      <= slip_tmr_d;
            lock_tmr_q      <= lock_tmr_d;
            rdy_tmr_q       <= rdy_tmr_d;
            hunt_cnt_q      <= hunt_cnt_d;
            correct_cnt_q   <= correct_cnt_d;
            rx_block_lock_q <= rx_block_lock_d;
            rx_bitslip_q    <= rx_bitslip_d;
            rdy_q           <= rdy_d;
            aligned_q       <= aligned_d;
            over_q          <= over_d;
            corr_seen_q     <= corr_seen_d;
            pma_hist_q      <= pma_hist_d;
            one_hist_q      <= one_hist_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT:      state_d = (bus.ctl_target_offset == 7'd0) ? ST_LOCK_WAIT : ST_HUNT;
            ST_HUNT:      if (hunt_cnt_q == target_q) state_d = ST_LOCK_WAIT;
            ST_LOCK_WAIT: begin
                if (bus.bs_gb_seq_sync)  state_d = ST_RESYNC;
                else if (lock_due)       state_d = ST_LOCKED;
            end
            ST_LOCKED:    if (bus.bs_gb_seq_sync) state_d = ST_RESYNC;
            ST_RESYNC:    if (!bus.bs_gb_seq_sync) state_d = ST_LOCK_WAIT;
            default:      state_d = ST_INIT;
        endcase
    end

    always_comb begin
        target_d        = (state_q == ST_INIT) ? bus.ctl_target_offset : target_q;
        slip_tmr_d      = slip_tmr_q;
        lock_tmr_d      = (state_q == ST_LOCK_WAIT) ? lock_tmr_q + 8'd1 : 8'd0;
        rdy_tmr_d       = rdy_tmr_q;
        rdy_d           = rdy_q;
        rx_bitslip_d    = slip_due;
        hunt_cnt_d      = hunt_cnt_q + {6'd0, slip_due};
        correct_cnt_d   = corr_sum[6:0];
        corr_seen_d     = corr_seen_q || (corr_inc != 2'd0);
        over_d          = over_q || ((corr_inc != 2'd0) && (corr_sum > {1'b0, hunt_cnt_q}));
        rx_block_lock_d = (state_d == ST_LOCKED);
        aligned_d       = aligned_q;
        pma_hist_d      = bus.bs_slip_pma;
        one_hist_d      = bus.bs_slip_one_ui;

        // The interval timer freezes while hunting is disabled.
        if (state_q != ST_HUNT) begin
            slip_tmr_d = 8'd0;
        end else if (!bus.bs_disable_bitslip) begin
            slip_tmr_d = slip_due ? 8'd0 : slip_tmr_q + 8'd1;
        end

        // The ready low period runs on regardless of state, so it survives RESYNC.
        if (pma_accept) begin
            rdy_d     = 1'b0;
            rdy_tmr_d = 8'd0;
        end else if (!rdy_q) begin
            if (rdy_tmr_q == 8'(RDY_LATENCY - 1)) rdy_d = 1'b1;
            else                                   rdy_tmr_d = rdy_tmr_q + 8'd1;
        end

        if ((state_q == ST_LOCK_WAIT) && (state_d == ST_LOCKED) && corr_seen_q) begin
            aligned_d = (hunt_cnt_q == correct_cnt_q);
        end
    end

    assign bus.rx_block_lock     = rx_block_lock_q;
    assign bus.rx_bitslip        = rx_bitslip_q;
    assign bus.rx_slip_pma_rdy   = rdy_q;
    assign bus.stat_hunt_cnt     = hunt_cnt_q;
    assign bus.stat_correct_cnt  = correct_cnt_q;
    assign bus.stat_residual     = hunt_cnt_q - correct_cnt_q;
    assign bus.stat_aligned      = aligned_q;
    assign bus.stat_over_correct = over_q;
endmodule

// File: tb/tb_gtfmac_hwchk_bitslip_responder.sv
// Bench for the bitslip responder: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_gtfmac_hwchk_bitslip_responder;
    localparam int SI = 16;
    localparam int RL = 8;
    localparam int LD = 4;

    localparam int M_INIT = 0, M_HUNT = 1, M_LW = 2, M_LOCKED = 3, M_RESYNC = 4;

    logic rx_clk   = 1'b0;
    logic rx_rst_n = 1'b1;
    always #5 rx_clk = ~rx_clk;

    gtfmac_hwchk_bitslip_responder_if bif();

    gtfmac_hwchk_bitslip_responder #(
        .SLIP_INTERVAL(SI),
        .RDY_LATENCY  (RL),
        .LOCK_DELAY   (LD)
    ) dut (
        .rx_clk  (rx_clk),
        .rx_rst_n(rx_rst_n),
        .bus     (bif)
    );

    int checks = 0;
    int errors = 0;
    int pulses[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_mode, m_target, m_hunt, m_corr, m_prog, m_lw, m_cyc, m_rdy_back;
    bit   m_corr_seen, m_prev_pma, m_prev_one;
    bit   e_lock, e_bs, e_rdy, e_aligned, e_over;

    task automatic model_reset();
        m_mode = M_INIT; m_target = 0; m_hunt = 0; m_corr = 0; m_prog = 0; m_lw = 0;
        m_cyc = 0; m_rdy_back = 0; m_corr_seen = 0; m_prev_pma = 0; m_prev_one = 0;
        e_lock = 0; e_bs = 0; e_rdy = 1; e_aligned = 0; e_over = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge rx_clk or negedge rx_rst_n);
            if (!rx_rst_n) begin
                model_reset();
            end else begin
                bit pr, orise, old_rdy, sync;
                int inc;
                m_cyc++;
                pr      = bif.bs_slip_pma && !m_prev_pma;
                orise   = bif.bs_slip_one_ui && !m_prev_one;
                sync    = bif.bs_gb_seq_sync;
                m_prev_pma = bif.bs_slip_pma;
                m_prev_one = bif.bs_slip_one_ui;
                old_rdy = e_rdy;
                e_bs    = 0;
                inc     = 0;
                if (!old_rdy && m_cyc >= m_rdy_back) e_rdy = 1;
                case (m_mode)
                    M_INIT: begin
                        m_target = int'(bif.ctl_target_offset);
                        m_mode   = (m_target == 0) ? M_LW : M_HUNT;
                        m_prog   = 0;
                        m_lw     = 0;
                    end
                    M_HUNT: begin
                        if (m_hunt == m_target) begin
                            m_mode = M_LW;
                            m_lw   = 0;
                        end else if (!bif.bs_disable_bitslip) begin
                            m_prog++;
                            if (m_prog % SI == 0) begin
                                e_bs = 1;
                                m_hunt++;
                            end
                        end
                    end
                    M_LW: begin
                        if (sync) begin
                            m_mode = M_RESYNC;
                        end else begin
                            m_lw++;
                            if (m_lw == LD) begin
                                m_mode = M_LOCKED;
                                if (m_corr_seen) e_aligned = (((m_hunt - m_corr) & 127) == 0);
                            end
                        end
                    end
                    M_LOCKED: begin
                        if (pr && old_rdy) begin
                            inc += 2;
                            e_rdy = 0;
                            m_rdy_back = m_cyc + RL;
                        end
                        if (orise) inc += 1;
                        if (sync) m_mode = M_RESYNC;
                    end
                    default: begin
                        if (!sync) begin
                            m_mode = M_LW;
                            m_lw   = 0;
                        end
                    end
                endcase
                if (inc != 0) begin
                    if (m_corr + inc > m_hunt) e_over = 1;
                    m_corr      = (m_corr + inc) % 128;
                    m_corr_seen = 1;
                end
                e_lock = (m_mode == M_LOCKED);
            end
        end
    end

    // One whole-output comparison per cycle, sampled on the falling edge.
    initial begin
        forever begin
            logic [31:0] act, exp;
            @(negedge rx_clk);
            act = {6'd0, bif.rx_block_lock, bif.rx_bitslip, bif.rx_slip_pma_rdy,
                   bif.stat_hunt_cnt, bif.stat_correct_cnt, bif.stat_residual,
                   bif.stat_aligned, bif.stat_over_correct};
            exp = {6'd0, e_lock, e_bs, e_rdy, 7'(m_hunt), 7'(m_corr), 7'((m_hunt - m_corr) & 127),
                   e_aligned, e_over};
            check("cycle_outputs", act, exp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    task automatic clear_inputs();
        bif.bs_gb_seq_sync     = 1'b0;
        bif.bs_disable_bitslip = 1'b0;
        bif.bs_slip_pma        = 1'b0;
        bif.bs_slip_one_ui     = 1'b0;
    endtask

    task automatic do_reset(input logic [6:0] tgt);
        clear_inputs();
        bif.ctl_target_offset = tgt;
        rx_rst_n = 1'b0;
        step(2);
        rx_rst_n = 1'b1;
    endtask

    task automatic wait_lock(input int budget, output int n);
        n = 0;
        pulses.delete();
        while (!bif.rx_block_lock && n < budget) begin
            step(1);
            n++;
            if (bif.rx_bitslip) pulses.push_back(n);
        end
        if (!bif.rx_block_lock) check("lock_timeout", 32'd0, 32'd1);
    endtask

    // Issues a slip-PMA request and toggles the request line while ready is low.
    task automatic pma_handshake(output int low);
        bif.bs_slip_pma = 1'b1;
        step(1);
        low = 0;
        for (int t = 0; t < 40 && !bif.rx_slip_pma_rdy; t++) begin
            low++;
            bif.bs_slip_pma = t[0];
            step(1);
        end
        bif.bs_slip_pma = 1'b0;
        step(1);
    endtask

    initial begin
        int n, low;
        int exp_p3[3];
        clear_inputs();
        bif.ctl_target_offset = 7'd0;
        #1 rx_rst_n = 1'b0;
        step(1);
        check("reset_rdy", 32'(bif.rx_slip_pma_rdy), 32'd1);
        check("reset_lock", 32'(bif.rx_block_lock), 32'd0);

        // Target 5: pulses 16 cycles apart from HUNT entry, lock 4 cycles after HUNT exit.
        do_reset(7'd5);
        wait_lock(300, n);
        check("s1_lock_cycle", 32'(n), 32'd86);
        check("s1_pulse_count", 32'(pulses.size()), 32'd5);
        foreach (pulses[i]) check("s1_pulse_cycle", 32'(pulses[i]), 32'(17 + 16 * i));
        check("s1_hunt_cnt", 32'(bif.stat_hunt_cnt), 32'd5);

        // Two slip-PMA handshakes, one one-UI slip, then an 8-cycle seq_sync.
        pma_handshake(low);
        check("s2_rdy_low_1", 32'(low), 32'(RL));
        check("s2_correct_after_1", 32'(bif.stat_correct_cnt), 32'd2);
        pma_handshake(low);
        check("s2_rdy_low_2", 32'(low), 32'(RL));
        check("s2_correct_after_2", 32'(bif.stat_correct_cnt), 32'd4);
        bif.bs_slip_one_ui = 1'b1;
        step(1);
        check("s2_correct_after_ui", 32'(bif.stat_correct_cnt), 32'd5);
        bif.bs_slip_one_ui = 1'b0;
        bif.bs_gb_seq_sync = 1'b1;
        step(1);
        check("s2_lock_drop", 32'(bif.rx_block_lock), 32'd0);
        step(7);
        bif.bs_gb_seq_sync = 1'b0;
        wait_lock(50, n);
        check("s2_relock_cycles", 32'(n), 32'(LD + 1));
        check("s2_aligned", 32'(bif.stat_aligned), 32'd1);
        check("s2_residual", 32'(bif.stat_residual), 32'd0);
        check("s2_over", 32'(bif.stat_over_correct), 32'd0);

        // Reset in the middle of a handshake releases ready immediately.
        bif.bs_slip_pma = 1'b1;
        step(1);
        check("s3_rdy_low", 32'(bif.rx_slip_pma_rdy), 32'd0);
        #2 rx_rst_n = 1'b0;
        #1;
        check("s3_async_rdy", 32'(bif.rx_slip_pma_rdy), 32'd1);
        check("s3_async_hunt", 32'(bif.stat_hunt_cnt), 32'd0);
        check("s3_async_correct", 32'(bif.stat_correct_cnt), 32'd0);
        check("s3_async_lock", 32'(bif.rx_block_lock), 32'd0);

        // Target 3 with hunting disabled for 40 cycles mid-interval.
        do_reset(7'd3);
        n = 0;
        pulses.delete();
        while (!bif.rx_block_lock && n < 300) begin
            bif.bs_disable_bitslip = (n >= 20 && n < 60);
            step(1);
            n++;
            if (bif.rx_bitslip) pulses.push_back(n);
        end
        bif.bs_disable_bitslip = 1'b0;
        check("s4_lock_cycle", 32'(n), 32'd94);
        check("s4_pulse_count", 32'(pulses.size()), 32'd3);
        exp_p3 = '{17, 73, 89};
        foreach (pulses[i]) if (i < 3) check("s4_pulse_cycle", 32'(pulses[i]), 32'(exp_p3[i]));
        check("s4_hunt_cnt", 32'(bif.stat_hunt_cnt), 32'd3);

        // Target 1 overcorrected by one slip-PMA.
        do_reset(7'd1);
        wait_lock(100, n);
        check("s5_lock_cycle", 32'(n), 32'd22);
        pma_handshake(low);
        check("s5_correct", 32'(bif.stat_correct_cnt), 32'd2);
        check("s5_over", 32'(bif.stat_over_correct), 32'd1);
        check("s5_residual", 32'(bif.stat_residual), 32'd127);

        // Randomized traffic, with an occasional asynchronous reset mid-run.
        for (int r = 0; r < 6; r++) begin
            int rst_at;
            do_reset(7'($urandom_range(0, 6)));
            rst_at = (r % 2 == 1) ? int'($urandom_range(50, 350)) : -1;
            for (int i = 0; i < 400; i++) begin
                bif.ctl_target_offset  = 7'($urandom_range(0, 127));
                bif.bs_disable_bitslip = ($urandom_range(0, 7) == 0);
                bif.bs_slip_pma        = ($urandom_range(0, 2) == 0);
                bif.bs_slip_one_ui     = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 29) == 0) bif.bs_gb_seq_sync = ~bif.bs_gb_seq_sync;
                if (i == rst_at) begin
                    bif.ctl_target_offset = 7'($urandom_range(0, 4));
                    #2 rx_rst_n = 1'b0;
                    @(posedge rx_clk);
                    #1 rx_rst_n = 1'b1;
                end else begin
                    step(1);
                end
            end
        end

        clear_inputs();
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
